// File: rtl/tdm_demux_4ch_if.sv
// TDM demux bus: shared slot line in, assembled frame and status out.
// Carries the optional framing-error signals (TDM_DEMUX_ERR_EN).
interface tdm_demux_4ch_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               sync;
    logic [4*WIDTH-1:0] out;
    logic               frame_valid;
    logic [3:0]         slot_sel;
    logic               sync_err;
    logic [7:0]         err_cnt;

    modport master (
        output din, din_valid, sync,
        input  out, frame_valid, slot_sel, sync_err, err_cnt
    );

    modport slave (
        input  din, din_valid, sync,
        output out, frame_valid, slot_sel, sync_err, err_cnt
    );
endinterface

// File: rtl/tdm_demux_4ch.sv
// 4-slot TDM demultiplexer with HUNT/LOCK frame alignment.
// Define TDM_DEMUX_ERR_EN to build the framing-error pulse and counter.
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux_4ch_if.slave bus
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                  state, state_d;
    logic [1:0]              cnt, cnt_d;
    logic [3:0][WIDTH-1:0]   cap;
    logic                    cap_we;
    logic [1:0]              cap_idx;
    logic                    done;
    logic                    err;

    // Next state, slot counter and capture control for one accepted beat.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cap_we  = 1'b0;
        cap_idx = cnt;
        done    = 1'b0;
        err     = 1'b0;
        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.sync) begin
                        cap_we  = 1'b1;
                        cap_idx = 2'd0;
                        cnt_d   = 2'd1;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.sync) begin
                        // resync: a mid-frame marker restarts the frame
                        cap_we  = 1'b1;
                        cap_idx = 2'd0;
                        cnt_d   = 2'd1;
                        err     = (cnt != 2'd0);
                    end else if (cnt == 2'd0) begin
                        // missing marker: lost alignment
                        state_d = HUNT;
                        cnt_d   = 2'd0;
                        err     = 1'b1;
                    end else begin
                        cap_we  = 1'b1;
                        cap_idx = cnt;
                        cnt_d   = cnt + 2'd1;
                        done    = (cnt == 2'd3);
                    end
                end
                default: ;
            endcase
        end
    end

    // State and slot counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            cnt   <= 2'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Per-slot capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap <= '0;
        end else if (cap_we) begin
            cap[cap_idx] <= bus.din;
        end
    end

    // Frame output: slot 3 arrives on din, so it is merged in directly
    // and the whole frame lands in out on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out         <= '0;
            bus.frame_valid <= 1'b0;
        end else begin
            bus.frame_valid <= done;
            if (done) begin
                bus.out <= {bus.din, cap[2], cap[1], cap[0]};
            end
        end
    end

    // Registered one-hot of the slot expected on the next beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.slot_sel <= 4'b0000;
        end else if (state_d == LOCK) begin
            bus.slot_sel <= 4'b0001 << cnt_d;
        end else begin
            bus.slot_sel <= 4'b0000;
        end
    end

`ifdef TDM_DEMUX_ERR_EN
    // Framing-error pulse and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sync_err <= 1'b0;
            bus.err_cnt  <= 8'h00;
        end else begin
            bus.sync_err <= err;
            if (err && bus.err_cnt != 8'hff) begin
                bus.err_cnt <= bus.err_cnt + 8'h01;
            end
        end
    end
`else
    logic unused_err;
    assign unused_err   = err;
    assign bus.sync_err = 1'b0;
    assign bus.err_cnt  = 8'h00;
`endif

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Testbench for tdm_demux_4ch: vector table, directed corner cases,
// and random beats against a queue-based frame model.
module tb_tdm_demux_4ch;

`ifdef TDM_DEMUX_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux_4ch_if #(.WIDTH(8)) bus ();

    tdm_demux_4ch #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int fails   = 0;

    // reference model state
    bit          locked;
    logic [7:0]  q[$];
    logic [31:0] m_out;
    bit          m_fv;
    logic [3:0]  m_sel;
    bit          m_err;
    int          m_cnt;

    typedef struct {
        bit          v;
        bit          s;
        logic [7:0]  d;
        logic [31:0] eo;
        bit          efv;
        logic [3:0]  esel;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " out"}, 64'(bus.out), 64'(m_out));
        chk({tag, " frame_valid"}, 64'(bus.frame_valid), 64'(m_fv));
        chk({tag, " slot_sel"}, 64'(bus.slot_sel), 64'(m_sel));
        chk({tag, " sync_err"}, 64'(bus.sync_err), 64'(m_err));
        chk({tag, " err_cnt"}, 64'(bus.err_cnt), 64'(m_cnt));
    endtask

    task automatic model_reset();
        locked = 1'b0;
        q.delete();
        m_out = '0;
        m_fv  = 1'b0;
        m_sel = 4'b0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic bump_err();
        if (ERR) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [7:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (s) begin
                if (locked && q.size() != 0) bump_err();
                q.delete();
                q.push_back(d);
                locked = 1'b1;
            end else if (locked) begin
                if (q.size() == 0) begin
                    bump_err();
                    locked = 1'b0;
                end else begin
                    q.push_back(d);
                    if (q.size() == 4) begin
                        m_out = {q[3], q[2], q[1], q[0]};
                        m_fv  = 1'b1;
                        q.delete();
                    end
                end
            end
        end
        m_sel = locked ? (4'b0001 << q.size()) : 4'b0000;
    endtask

    task automatic step(input bit v, input bit s, input logic [7:0] d,
                        input string tag);
        bus.din_valid = v;
        bus.sync      = s;
        bus.din       = d;
        @(posedge clk);
        model_beat(v, s, d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.din       = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("post_reset");
    endtask

    initial begin
        int fv_seen;
        int err_seen;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.din       = '0;
        model_reset();

        tbl[0]  = '{1'b1, 1'b0, 8'hAA, 32'h0,        1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 8'hBB, 32'h0,        1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 8'h11, 32'h0,        1'b0, 4'b0010};
        tbl[3]  = '{1'b1, 1'b0, 8'h22, 32'h0,        1'b0, 4'b0100};
        tbl[4]  = '{1'b1, 1'b0, 8'h33, 32'h0,        1'b0, 4'b1000};
        tbl[5]  = '{1'b1, 1'b0, 8'h44, 32'h44332211, 1'b1, 4'b0001};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 32'h44332211, 1'b0, 4'b0001};
        tbl[7]  = '{1'b1, 1'b1, 8'h01, 32'h44332211, 1'b0, 4'b0010};
        tbl[8]  = '{1'b1, 1'b0, 8'h02, 32'h44332211, 1'b0, 4'b0100};
        tbl[9]  = '{1'b1, 1'b0, 8'h03, 32'h44332211, 1'b0, 4'b1000};
        tbl[10] = '{1'b1, 1'b0, 8'h04, 32'h04030201, 1'b1, 4'b0001};
        tbl[11] = '{1'b1, 1'b0, 8'h99, 32'h04030201, 1'b0, 4'b0000};

        do_reset();

        // table vectors: hunt discard, basic frame, stall, slot-0 error
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d out", i), 64'(bus.out), 64'(tbl[i].eo));
            chk($sformatf("tbl%0d fv", i), 64'(bus.frame_valid),
                64'(tbl[i].efv));
            chk($sformatf("tbl%0d sel", i), 64'(bus.slot_sel),
                64'(tbl[i].esel));
        end
        chk("tbl err_cnt", 64'(bus.err_cnt), 64'(ERR ? 1 : 0));

        // stall in the middle of a frame
        do_reset();
        step(1, 1, 8'h11, "stall");
        step(1, 0, 8'h22, "stall");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'hEE, "stall_gap");
            chk("stall sel", 64'(bus.slot_sel), 64'(4'b0100));
            chk("stall fv", 64'(bus.frame_valid), 64'(0));
        end
        step(1, 0, 8'h33, "stall");
        chk("stall fv early", 64'(bus.frame_valid), 64'(0));
        step(1, 0, 8'h44, "stall");
        chk("stall out", 64'(bus.out), 64'(32'h44332211));
        chk("stall fv", 64'(bus.frame_valid), 64'(1));
        step(0, 0, 8'h00, "stall_after");
        chk("stall fv pulse", 64'(bus.frame_valid), 64'(0));

        // mid-frame resync
        do_reset();
        fv_seen  = 0;
        err_seen = 0;
        step(1, 1, 8'h10, "resync");
        fv_seen += int'(bus.frame_valid);
        err_seen += int'(bus.sync_err);
        step(1, 0, 8'h20, "resync");
        fv_seen += int'(bus.frame_valid);
        err_seen += int'(bus.sync_err);
        step(1, 1, 8'h50, "resync");
        fv_seen += int'(bus.frame_valid);
        err_seen += int'(bus.sync_err);
        step(1, 0, 8'h60, "resync");
        fv_seen += int'(bus.frame_valid);
        err_seen += int'(bus.sync_err);
        step(1, 0, 8'h70, "resync");
        fv_seen += int'(bus.frame_valid);
        err_seen += int'(bus.sync_err);
        step(1, 0, 8'h80, "resync");
        fv_seen += int'(bus.frame_valid);
        err_seen += int'(bus.sync_err);
        chk("resync out", 64'(bus.out), 64'(32'h80706050));
        chk("resync fv count", 64'(fv_seen), 64'(1));
        chk("resync err pulses", 64'(err_seen), 64'(ERR ? 1 : 0));
        chk("resync err_cnt", 64'(bus.err_cnt), 64'(ERR ? 1 : 0));

        // repeated slot-0 errors saturate the counter
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, 1, 8'(i), "sat");
            step(1, 0, 8'h02, "sat");
            step(1, 0, 8'h03, "sat");
            step(1, 0, 8'h04, "sat");
            step(1, 0, 8'h99, "sat_err");
            if (i == 0) begin
                chk("err sel", 64'(bus.slot_sel), 64'(0));
                chk("err out", 64'(bus.out), 64'(32'h04030200));
                chk("err cnt1", 64'(bus.err_cnt), 64'(ERR ? 1 : 0));
            end
        end
        chk("sat err_cnt", 64'(bus.err_cnt), 64'(ERR ? 255 : 0));

        // reset mid-frame
        do_reset();
        step(1, 1, 8'hA1, "midrst");
        step(1, 0, 8'hA2, "midrst");
        do_reset();
        chk("midrst out", 64'(bus.out), 64'(0));
        step(1, 0, 8'hA3, "midrst_after");
        chk("midrst fv", 64'(bus.frame_valid), 64'(0));
        step(1, 0, 8'hA4, "midrst_after");
        chk("midrst fv2", 64'(bus.frame_valid), 64'(0));
        chk("midrst sel", 64'(bus.slot_sel), 64'(0));

        // random beats against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                     8'($urandom), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter WIDTH, default 8, data width of each time slot and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 din  input  WIDTH  shared time-multiplexed data line, one slot per accepted beat.
REQ-005 din_valid  input  1  beat qualifier; din and sync are sampled only when high.
REQ-006 sync  input  1  frame marker; high on the beat carrying slot 0.
REQ-007 out  output  4*WIDTH  registered frame; slot k occupies bits [k*WIDTH +: WIDTH].
REQ-008 frame_valid  output  1  one-cycle pulse when out is updated with a complete frame.
REQ-009 slot_sel  output  4  one-hot slot expected on the next beat; 4'b0000 while hunting.
REQ-010 sync_err  output  1  one-cycle pulse on a framing error; tied 0 without TDM_DEMUX_ERR_EN.
REQ-011 err_cnt  output  8  saturating framing-error count; tied 0 without TDM_DEMUX_ERR_EN.

Function
REQ-012 The block SHALL have two states, HUNT and LOCK, plus a 2-bit slot counter.
REQ-013 In HUNT, beats with sync=0 SHALL be discarded with no output change.
REQ-014 In HUNT, a beat with sync=1 SHALL be captured as slot 0, the slot counter set to 1, and the state set to LOCK.
REQ-015 In LOCK, each beat SHALL be captured into the capture register for the current slot, and the counter SHALL increment, wrapping 3->0.
REQ-016 Cycles with din_valid=0 SHALL leave state, counter, capture registers and outputs unchanged (stall).
REQ-017 The cycle after the slot-3 beat is accepted, out SHALL load all four capture registers atomically and frame_valid SHALL pulse high for exactly one cycle.
REQ-018 out SHALL hold its value between completed frames; partial frames SHALL never reach out.
REQ-019 In LOCK, a sync=1 beat at slot 0 is normal; a sync=1 beat at slots 1-3 SHALL discard the partial frame, capture the beat as slot 0, set the counter to 1, remain in LOCK, and count as a framing error.
REQ-020 In LOCK, a sync=0 beat at slot 0 SHALL discard the beat, go to HUNT, and count as a framing error.
REQ-021 A slot-3 beat completing a frame SHALL produce frame_valid even if the next accepted beat is a framing error.
REQ-022 slot_sel SHALL be the registered one-hot decode of the counter in LOCK and all zeros in HUNT.
REQ-023 frame_valid SHALL be low in every cycle not covered by REQ-017.

Reset
REQ-024 While rst_n=0: state HUNT, counter 0, capture registers 0, out 0, frame_valid 0, slot_sel 0, sync_err 0, err_cnt 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid SHALL follow the release.
REQ-026 The first beat after reset release SHALL be processed under the HUNT rules.

Configuration
REQ-027 Macro TDM_DEMUX_ERR_EN defined: sync_err SHALL pulse for one cycle, the cycle after each framing error beat, and err_cnt SHALL increment by 1, saturating at 255.
REQ-028 Macro TDM_DEMUX_ERR_EN undefined: error logic SHALL be absent, sync_err and err_cnt SHALL be constant 0, and all framing behaviour SHALL be otherwise identical.

Verification
REQ-029 Reset, then beats (sync,din)=(1,0x11),(0,0x22),(0,0x33),(0,0x44) -> out=0x44332211, frame_valid high for exactly one cycle, one cycle after the 0x44 beat.
REQ-030 Same frame with din_valid low for 3 cycles between the 0x22 and 0x33 beats -> identical out; frame_valid delayed by exactly 3 cycles; slot_sel holds 4'b0100 during the stall.
REQ-031 Beats (0,0xAA),(0,0xBB) in HUNT, then a valid frame 0x01..0x04 -> 0xAA and 0xBB are ignored; out=0x04030201.
REQ-032 Locked, beats (1,0x10),(0,0x20),(1,0x50),(0,0x60),(0,0x70),(0,0x80) -> no frame_valid for the 0x10 frame; out=0x80706050; with ERR_EN sync_err pulses once and err_cnt=1.
REQ-033 After a complete frame, beat (0,0x99) at slot 0 -> HUNT, slot_sel=0, out unchanged; with ERR_EN err_cnt increments; 300 such errors -> err_cnt=255.
REQ-034 rst_n pulsed low after two beats of a frame -> all outputs 0; the following two beats with sync=0 produce no frame_valid.
